// File: rtl/eqv_mismatch_monitor_if.sv
// eqv_mismatch_monitor_if: compared outputs, control pulses and mismatch status for eqv_mismatch_monitor
interface eqv_mismatch_monitor_if #(
  parameter int WIDTH = 91,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] y_1;
  logic [WIDTH-1:0] y_2;
  logic arm;
  logic clear;
  logic [1:0] state;
  logic mismatch_now;
  logic mismatch_any;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] first_cycle;
  logic [WIDTH-1:0] first_diff;
  logic [WIDTH-1:0] first_y1;
  logic [WIDTH-1:0] first_y2;
  modport master (
    output y_1, y_2, arm, clear,
    input  state, mismatch_now, mismatch_any, mismatch_cnt, cycle_cnt,
           first_cycle, first_diff, first_y1, first_y2
  );
  modport slave (
    input  y_1, y_2, arm, clear,
    output state, mismatch_now, mismatch_any, mismatch_cnt, cycle_cnt,
           first_cycle, first_diff, first_y1, first_y2
  );
endinterface

// File: rtl/eqv_mismatch_monitor.sv
// eqv_mismatch_monitor: sticky, counting compare of paired equivalence outputs.
// Define EQV_FULL_CAPTURE_EN to also keep y_1/y_2 of the first mismatch.
module eqv_mismatch_monitor #(
  parameter int WIDTH  = 91,
  parameter int CNT_W  = 16,
  parameter int WARMUP = 4
) (
  input logic clk,
  input logic rst,
  eqv_mismatch_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WARM, CHECK, TRIP} state_e;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [WIDTH-1:0] y1_q, y2_q, diff_q;
  logic v_q, now_q, any_q, hit;
  logic [CNT_W-1:0] mcnt_q, ccnt_q, fcyc_q;
  assign hit = v_q & (y1_q != y2_q);
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (bus.clear) begin
      state_d = IDLE;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.arm) begin
          state_d = (WARMUP == 0) ? CHECK : WARM;
          wcnt_d  = '0;
        end
        WARM: begin
          wcnt_d  = wcnt_q + 8'd1;
          state_d = (wcnt_q == 8'(WARMUP - 1)) ? CHECK : WARM;
        end
        CHECK: state_d = hit ? TRIP : CHECK;
        default: state_d = TRIP;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      v_q     <= 1'b0;
      now_q   <= 1'b0;
      any_q   <= 1'b0;
      mcnt_q  <= '0;
      ccnt_q  <= '0;
      fcyc_q  <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      y1_q    <= bus.y_1;
      y2_q    <= bus.y_2;
      if (bus.clear) begin
        v_q    <= 1'b0;
        now_q  <= 1'b0;
        any_q  <= 1'b0;
        mcnt_q <= '0;
        ccnt_q <= '0;
        fcyc_q <= '0;
        diff_q <= '0;
      end else begin
        v_q   <= (state_q == CHECK) || (state_q == TRIP);
        now_q <= hit;
        any_q <= any_q | hit;
        if (v_q && ccnt_q != CMAX) ccnt_q <= ccnt_q + 1'b1;
        if (hit && mcnt_q != CMAX) mcnt_q <= mcnt_q + 1'b1;
        if (hit && !any_q) begin
          fcyc_q <= ccnt_q;
          diff_q <= y1_q ^ y2_q;
        end
      end
    end
  end
`ifdef EQV_FULL_CAPTURE_EN
  logic [WIDTH-1:0] fy1_q, fy2_q;
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      fy1_q <= '0;
      fy2_q <= '0;
    end else if (hit && !any_q) begin
      fy1_q <= y1_q;
      fy2_q <= y2_q;
    end
  end
  assign bus.first_y1 = fy1_q;
  assign bus.first_y2 = fy2_q;
`else
  assign bus.first_y1 = '0;
  assign bus.first_y2 = '0;
`endif
  assign bus.state        = state_q;
  assign bus.mismatch_now = now_q;
  assign bus.mismatch_any = any_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.cycle_cnt    = ccnt_q;
  assign bus.first_cycle  = fcyc_q;
  assign bus.first_diff   = diff_q;
endmodule

// File: tb/tb_eqv_mismatch_monitor.sv
// tb_eqv_mismatch_monitor: directed vectors against hand-computed expectations
module tb_eqv_mismatch_monitor;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  eqv_mismatch_monitor_if #(.WIDTH(91), .CNT_W(16)) bif ();
  eqv_mismatch_monitor_if #(.WIDTH(8), .CNT_W(4)) sif ();
  eqv_mismatch_monitor #(.WIDTH(91), .CNT_W(16), .WARMUP(4)) dut (.clk(clk), .rst(rst), .bus(bif));
  eqv_mismatch_monitor #(.WIDTH(8), .CNT_W(4), .WARMUP(0)) dut_sat (.clk(clk), .rst(rst), .bus(sif));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_status(input string tag, input logic [1:0] st, input logic now, input logic any,
                            input logic [15:0] mc, input logic [15:0] cc, input logic [15:0] fc,
                            input logic [90:0] fd);
    chk({tag, ".state"}, 128'(bif.state), 128'(st));
    chk({tag, ".now"}, 128'(bif.mismatch_now), 128'(now));
    chk({tag, ".any"}, 128'(bif.mismatch_any), 128'(any));
    chk({tag, ".mcnt"}, 128'(bif.mismatch_cnt), 128'(mc));
    chk({tag, ".ccnt"}, 128'(bif.cycle_cnt), 128'(cc));
    chk({tag, ".fcyc"}, 128'(bif.first_cycle), 128'(fc));
    chk({tag, ".fdiff"}, 128'(bif.first_diff), 128'(fd));
  endtask
  initial begin
    rst = 1'b1;
    bif.y_1 = '0; bif.y_2 = '0; bif.arm = 1'b0; bif.clear = 1'b0;
    sif.y_1 = '0; sif.y_2 = '0; sif.arm = 1'b0; sif.clear = 1'b0;
    tick(2);
    chk_status("reset", 2'b00, 0, 0, 0, 0, 0, 0);
    chk("reset.fy1", 128'(bif.first_y1), 0);
    chk("reset.fy2", 128'(bif.first_y2), 0);
    rst = 1'b0;
    tick(50);
    chk_status("idle50", 2'b00, 0, 0, 0, 0, 0, 0);
    // warmup: mismatching inputs for the four warmup samples are ignored
    bif.arm = 1'b1;
    tick();
    bif.arm = 1'b0;
    chk("warm.state", 128'(bif.state), 128'(2'b01));
    bif.y_1 = 91'h5; bif.y_2 = 91'h6;
    tick(4);
    chk("warm.to_check", 128'(bif.state), 128'(2'b10));
    bif.y_1 = '0; bif.y_2 = '0;
    tick(6);
    chk_status("warm.done", 2'b10, 0, 0, 0, 5, 0, 0);
    tick(4);
    // eleventh checked sample mismatches
    bif.y_1 = 91'h1; bif.y_2 = 91'h3;
    tick();
    bif.y_1 = '0; bif.y_2 = '0;
    chk("first.pre_now", 128'(bif.mismatch_now), 0);
    chk("first.pre_state", 128'(bif.state), 128'(2'b10));
    tick();
    chk_status("first", 2'b11, 1, 1, 1, 11, 10, 91'h2);
`ifdef EQV_FULL_CAPTURE_EN
    chk("first.fy1", 128'(bif.first_y1), 128'h1);
    chk("first.fy2", 128'(bif.first_y2), 128'h3);
`else
    chk("first.fy1", 128'(bif.first_y1), 0);
    chk("first.fy2", 128'(bif.first_y2), 0);
`endif
    tick();
    chk("first.pulse_end", 128'(bif.mismatch_now), 0);
    for (int i = 0; i < 5; i++) begin
      bif.y_1 = 91'(i + 4); bif.y_2 = 91'(i + 100);
      tick();
    end
    bif.y_1 = '0; bif.y_2 = '0;
    tick(2);
    chk_status("cont", 2'b11, 0, 1, 6, 19, 10, 91'h2);
`ifdef EQV_FULL_CAPTURE_EN
    chk("cont.fy1", 128'(bif.first_y1), 128'h1);
`endif
    // clear and arm together with a mismatch in the pipeline
    bif.y_1 = 91'h7; bif.y_2 = 91'h9;
    tick();
    bif.clear = 1'b1; bif.arm = 1'b1;
    tick();
    bif.clear = 1'b0; bif.arm = 1'b0;
    chk_status("clear", 2'b00, 0, 0, 0, 0, 0, 0);
    chk("clear.fy1", 128'(bif.first_y1), 0);
    tick();
    chk_status("clear.flush", 2'b00, 0, 0, 0, 0, 0, 0);
    bif.arm = 1'b1;
    tick();
    bif.arm = 1'b0;
    chk("rearm.state", 128'(bif.state), 128'(2'b01));
    bif.y_1 = '0; bif.y_2 = '0;
    tick(4);
    bif.y_1 = 91'h18; bif.y_2 = 91'h8;
    tick();
    bif.y_1 = '0; bif.y_2 = '0;
    tick();
    chk_status("rearm", 2'b11, 1, 1, 1, 1, 0, 91'h10);
    // saturation on the narrow-counter instance with no warmup
    sif.arm = 1'b1;
    tick();
    sif.arm = 1'b0;
    chk("sat.state0", 128'(sif.state), 128'(2'b10));
    sif.y_1 = 8'h1; sif.y_2 = 8'h2;
    tick(22);
    chk("sat.ccnt", 128'(sif.cycle_cnt), 128'd15);
    chk("sat.mcnt", 128'(sif.mismatch_cnt), 128'd15);
    chk("sat.state", 128'(sif.state), 128'(2'b11));
    chk("sat.fcyc", 128'(sif.first_cycle), 0);
    chk("sat.fdiff", 128'(sif.first_diff), 128'h3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/eqv_mismatch_monitor.md
Name: eqv_mismatch_monitor

Overview:
- Downstream consumer of an equivalence-proof top: compares the paired design outputs y_1/y_2 every clock and records divergence.
- Replaces the bare per-cycle assert with sticky, countable, debuggable mismatch status usable in simulation benches and formal cover properties.
- Sits beside the two design instances; takes only their outputs plus a control handshake.

Parameters:
- WIDTH, 91, bit width of each compared output vector (y_1/y_2 are [WIDTH-1:0]).
- CNT_W, 16, width of the cycle and mismatch counters; both saturate.
- WARMUP, 4, checked-window cycles ignored after arming (range 0..255).

Ports:
- clk  in  1  rising-edge clock, the design-under-proof clock.
- rst  in  1  synchronous active-high reset.
- y_1  in  WIDTH  output of first design instance.
- y_2  in  WIDTH  output of second design instance.
- arm  in  1  single-cycle pulse: start checking from IDLE.
- clear  in  1  single-cycle pulse: return to IDLE, zero all status.
- state  out  2  00 IDLE, 01 WARMUP, 10 CHECK, 11 TRIPPED.
- mismatch_now  out  1  registered per-sample compare result.
- mismatch_any  out  1  sticky: at least one mismatch since arm.
- mismatch_cnt  out  CNT_W  number of mismatching checked samples, saturating.
- cycle_cnt  out  CNT_W  number of checked samples, saturating.
- first_cycle  out  CNT_W  cycle_cnt index of the first mismatching sample.
- first_diff  out  WIDTH  y_1 XOR y_2 of the first mismatching sample.
- first_y1  out  WIDTH  y_1 of the first mismatch (optional feature).
- first_y2  out  WIDTH  y_2 of the first mismatch (optional feature).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; every output is 0; the input pipeline is cleared and its valid bit is 0. rst has priority over clear and arm.
- Stage 1, edge k:
  - y1_q <= y_1 and y2_q <= y_2.
  - v_q <= 1 only when state is CHECK or TRIPPED before edge k.
- Stage 2, edge k+1:
  - mismatch_now <= v_q & (y1_q != y2_q).
  - Fixed latency of 2 edges from sampling to mismatch_now.
  - Counters and captures update on the same edge.
- FSM:
  - IDLE, arm=1 -> WARMUP, or CHECK directly when WARMUP=0. The warmup counter loads 0.
  - WARMUP: the counter increments each cycle; on reaching WARMUP-1 -> CHECK. No samples are validated.
  - CHECK: stays until the stage-2 compare fires, then -> TRIPPED on that edge.
  - TRIPPED: terminal until clear or rst. Comparison and counting continue.
  - clear=1 in any state -> IDLE, with all status outputs zeroed on that edge. Pipeline v_q is also zeroed so no in-flight sample counts.
  - arm outside IDLE is ignored. arm and clear in the same cycle: clear wins.
- Counters:
  - cycle_cnt increments for each stage-2 sample with v_q=1.
  - mismatch_cnt increments when mismatch_now is set.
  - Both hold at 2^CNT_W-1 and never wrap.
- First capture:
  - Taken on the stage-2 edge where the compare fires while mismatch_any=0.
  - first_cycle = cycle_cnt value before its increment (0-based), first_diff = y1_q^y2_q.
  - Frozen afterwards until clear or rst.
- mismatch_any sets with the first mismatch_now and is sticky.
- Samples in flight when leaving CHECK/TRIPPED via clear are discarded.

Optional Feature:
- Macro EQV_FULL_CAPTURE_EN.
- Defined: first_y1/first_y2 capture y1_q/y2_q on the same edge as first_diff; frozen and cleared identically.
- Undefined: the ports exist but are tied to 0 with no storage, saving 2*WIDTH flops. All other behaviour is unchanged.

Test Plan:
- Reset/idle: rst for 2 cycles, y_1=y_2=0 -> all outputs 0, state=00. arm never given -> cycle_cnt stays 0 for 50 cycles.
- Warmup masking: WARMUP=4, arm, y_1!=y_2 during the 4 warmup cycles, then equal -> mismatch_any=0. cycle_cnt counts only post-warmup samples.
- First mismatch: arm, equal for 10 checked samples, then y_1=91'h1, y_2=91'h3 for one cycle:
  - mismatch_now pulses 2 edges after that sample.
  - first_cycle=10, first_diff=91'h2, state=TRIPPED, mismatch_cnt=1.
  - With EQV_FULL_CAPTURE_EN: first_y1=1, first_y2=3.
- Continued counting: in TRIPPED, inject 5 more mismatches with different values -> mismatch_cnt=6, first_* unchanged.
- Saturation: CNT_W=4, 20 mismatching checked samples -> cycle_cnt=15, mismatch_cnt=15, no wrap.
- Clear/arm race: clear and arm in the same cycle while TRIPPED, with a mismatch in flight -> IDLE, all status 0, in-flight sample not counted. A following arm restarts cleanly.
